// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The master drives the request side, the slave (the divider) drives results.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dz
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional macro SEQ_DIVIDER_DZ_FAST_EN: a divide-by-zero request finishes one
// edge after capture instead of running all WIDTH iterations.
//
//   state | meaning
//   IDLE  | waiting for start, busy=0, results held
//   RUN   | iterating, busy=1, start ignored
module seq_divider #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dz;
    logic             r_done;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_dz_fast;
    logic             w_last;

    // One restoring step: shift in next dividend bit, trial-subtract divisor.
    // The top bit of w_shift set means the value already exceeds any divisor;
    // otherwise a borrow out of the trial means the subtraction is rejected.
    always_comb begin
        w_shift    = {r_rem, r_dvd[WIDTH-1]};
        w_trial    = w_shift - {1'b0, r_dvs};
        w_ge       = w_shift[WIDTH] | ~w_trial[WIDTH];
        w_rem_next = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end

`ifdef SEQ_DIVIDER_DZ_FAST_EN
    assign w_dz_fast = (r_dvs == '0);
`else
    assign w_dz_fast = 1'b0;
`endif

    assign w_last = w_dz_fast || (r_cnt == '0);

    // Control, datapath and result registers.
    // r_dvd doubles as the quotient shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dvd   <= bus.dividend;
                        r_dvs   <= bus.divisor;
                        r_rem   <= '0;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_state     <= IDLE;
                        r_done      <= 1'b1;
                        r_dz        <= (r_dvs == '0);
                        r_quotient  <= w_dz_fast ? '1 : {r_dvd[WIDTH-2:0], w_ge};
                        r_remainder <= w_dz_fast ? r_dvd : w_rem_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state == RUN);
    assign bus.done      = r_done;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.dz        = r_dz;
endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

`ifdef SEQ_DIVIDER_DZ_FAST_EN
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 8;
`endif

    seq_divider_if #(.WIDTH(8)) bus ();

    seq_divider #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Launch one request (start high for a single edge) and wait for done.
    // Returns latency in edges after capture (-1 on timeout) and the number
    // of in-flight cycles that showed busy low.
    task automatic run_op(input logic [7:0] dd, input logic [7:0] dv,
                          output int lat, output int busy_bad);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        busy_bad = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.dz} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.dz);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bb;
        run_op(8'd200, 8'd7, lat, bb);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", lat); end
        checks++;
        if (bb !== 0) begin errors++; $display("FAIL basic_busy: %0d cycles busy low, want 0", bb); end
        checks++;
        if ({bus.quotient, bus.remainder, bus.dz, bus.busy} !== {8'd28, 8'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b busy=%b want q=28 r=4 dz=0 busy=0",
                     bus.quotient, bus.remainder, bus.dz, bus.busy);
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.done, bus.quotient, bus.remainder} !== {1'b0, 8'd28, 8'd4}) begin
            errors++;
            $display("FAIL basic_hold: got done=%b q=%0d r=%0d want done=0 q=28 r=4",
                     bus.done, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_edges();
        int lat, bb;
        run_op(8'd255, 8'd1, lat, bb);
        checks++;
        if (lat !== 8 || {bus.quotient, bus.remainder, bus.dz} !== {8'd255, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL div_255_1: got lat=%0d q=%0d r=%0d dz=%b want lat=8 q=255 r=0 dz=0",
                     lat, bus.quotient, bus.remainder, bus.dz);
        end
        run_op(8'd5, 8'd9, lat, bb);
        checks++;
        if (lat !== 8 || {bus.quotient, bus.remainder, bus.dz} !== {8'd0, 8'd5, 1'b0}) begin
            errors++;
            $display("FAIL div_5_9: got lat=%0d q=%0d r=%0d dz=%b want lat=8 q=0 r=5 dz=0",
                     lat, bus.quotient, bus.remainder, bus.dz);
        end
    endtask

    task automatic test_div_zero();
        int lat, bb;
        run_op(8'h5A, 8'h00, lat, bb);
        checks++;
        if (lat !== DZ_LAT) begin errors++; $display("FAIL dz_latency: got %0d want %0d", lat, DZ_LAT); end
        checks++;
        if (bb !== 0) begin errors++; $display("FAIL dz_busy: %0d cycles busy low, want 0", bb); end
        checks++;
        if ({bus.quotient, bus.remainder, bus.dz} !== {8'hFF, 8'h5A, 1'b1}) begin
            errors++;
            $display("FAIL dz_result: got q=%h r=%h dz=%b want q=ff r=5a dz=1",
                     bus.quotient, bus.remainder, bus.dz);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (2) begin @(posedge clk); #1; lat++; end
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
        @(posedge clk); #1; lat++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL ignore_latency: got %0d want 8", lat); end
        checks++;
        if ({bus.quotient, bus.remainder} !== {8'd33, 8'd1}) begin
            errors++;
            $display("FAIL ignore_result: got q=%0d r=%0d want q=33 r=1", bus.quotient, bus.remainder);
        end
        bus.dividend = 8'd0; bus.divisor = 8'd1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bb;
        run_op(8'd200, 8'd7, lat, bb);
        checks++;
        if (lat !== 8 || {bus.quotient, bus.remainder} !== {8'd28, 8'd4}) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d want lat=8 q=28 r=4",
                     lat, bus.quotient, bus.remainder);
        end
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
        end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 8 || {bus.quotient, bus.remainder} !== {8'd4, 8'd1}) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d want lat=8 q=4 r=1",
                     lat, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bb, seen;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.dz} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.dz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_nodone: %0d active cycles, want 0", seen); end
        run_op(8'd200, 8'd7, lat, bb);
        checks++;
        if (lat !== 8 || {bus.quotient, bus.remainder} !== {8'd28, 8'd4}) begin
            errors++;
            $display("FAIL midreset_restart: got lat=%0d q=%0d r=%0d want lat=8 q=28 r=4",
                     lat, bus.quotient, bus.remainder);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
